// File: rtl/mult_pkg.sv
// Purpose: shared state encoding, sizing helpers and parameter check for the iterative multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_KBITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Number of digit iterations needed to consume the whole multiplier.
    function automatic int n_iter(input int width, input int kbits);
        return width / kbits;
    endfunction

    // Counter width for the digit index.
    function automatic int cnt_w(input int width, input int kbits);
        return (width / kbits) > 1 ? $clog2(width / kbits) : 1;
    endfunction

    // Radix must be 2, 4 or 16, and the digit size must tile the operand exactly.
    function automatic bit params_ok(input int width, input int kbits);
        return (kbits == 1 || kbits == 2 || kbits == 4) &&
               (width >= 2 * kbits) && ((width % kbits) == 0);
    endfunction

endpackage

// File: rtl/mult_iter_param_if.sv
// Purpose: start/abort/operand request and product/valid/busy response bundle of the multiplier.
// Latency: n/a (wiring only).
// Backpressure: requester must hold off while BUSY is high; starts during BUSY are dropped.
interface mult_iter_param_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 MST;
    logic                 MABORT;
    logic                 MSGNA;
    logic                 MSGNB;
    logic [WIDTH-1:0]     SRCA;
    logic [WIDTH-1:0]     SRCB;
    logic [2*WIDTH-1:0]   PROD;
    logic                 PRODV;
    logic                 BUSY;

    modport master (
        output MST, MABORT, MSGNA, MSGNB, SRCA, SRCB,
        input  PROD, PRODV, BUSY
    );

    modport slave (
        input  MST, MABORT, MSGNA, MSGNB, SRCA, SRCB,
        output PROD, PRODV, BUSY
    );
endinterface

// File: rtl/mult_digit_pp.sv
// Purpose: one radix-2^KBITS partial product, optional negative weight on the digit MSB.
// Latency: combinational.
// Backpressure: none.
module mult_digit_pp #(
    parameter int WIDTH = 32,
    parameter int KBITS = 2
) (
    input  logic [2*WIDTH-1:0] a_i,
    input  logic [KBITS-1:0]   dig_i,
    input  logic               neg_msb_i,
    output logic [2*WIDTH-1:0] pp_o
);
    // Sum (or subtract, for the sign bit of a signed multiplier) the shifted multiplicand per set digit bit.
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < KBITS; i++) begin
            if (dig_i[i]) begin
                if ((i == KBITS - 1) && neg_msb_i) begin
                    pp_o = pp_o - (a_i << i);
                end else begin
                    pp_o = pp_o + (a_i << i);
                end
            end
        end
    end
endmodule

// File: rtl/mult_iter_param.sv
// Purpose: iterative WIDTHxWIDTH multiplier, KBITS multiplier bits per cycle, per-operand signedness.
// Latency: PRODV N_ITER cycles after accept (MULT_EARLY_EXIT_EN: stops after highest nonzero digit).
// Backpressure: MST ignored while BUSY; MABORT cancels work and result, wins over MST.
module mult_iter_param
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KBITS = DEF_KBITS
) (
    input  logic              CLK,
    input  logic              RST_N,
    mult_iter_param_if.slave  bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int N_ITER = n_iter(WIDTH, KBITS);
    localparam int CNT_W  = cnt_w(WIDTH, KBITS);

    if (!params_ok(WIDTH, KBITS)) begin : g_param_err
        $error("mult_iter_param: KBITS must be 1, 2 or 4 and divide WIDTH");
    end

    mult_state_e        state_q, state_d;
    logic [PW-1:0]      a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               sgnb_q;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      prod_q;
    logic               prodv_q;

    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      pp;
    logic               last;
    logic               finish;
    logic               accept;

    assign a_ext  = bus.MSGNA ? {{WIDTH{bus.SRCA[WIDTH-1]}}, bus.SRCA}
                              : {{WIDTH{1'b0}}, bus.SRCA};
    assign accept = bus.MST & ~bus.MABORT & (state_q != RUN);
    assign last   = (cnt_q == CNT_W'(N_ITER - 1));

`ifdef MULT_EARLY_EXIT_EN
    // A negative signed multiplier keeps its MSB set, so it can only finish on the last digit.
    assign finish = last | ((b_sh_q >> KBITS) == '0);
`else
    assign finish = last;
`endif

    mult_digit_pp #(
        .WIDTH (WIDTH),
        .KBITS (KBITS)
    ) u_digit_pp (
        .a_i       (a_sh_q),
        .dig_i     (b_sh_q[KBITS-1:0]),
        .neg_msb_i (sgnb_q & last),
        .pp_o      (pp)
    );

    assign acc_d = acc_q + pp;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort beats everything, otherwise start from IDLE/DONE and finish out of RUN.
    always_comb begin
        state_d = state_q;
        if (bus.MABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (bus.MST) state_d = RUN;
                RUN:        if (finish)  state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Operand capture, shift-and-accumulate datapath and held result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sgnb_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            prodv_q <= 1'b0;
        end else if (bus.MABORT) begin
            prodv_q <= 1'b0;
        end else if (accept) begin
            a_sh_q  <= a_ext;
            b_sh_q  <= bus.SRCB;
            sgnb_q  <= bus.MSGNB;
            acc_q   <= '0;
            cnt_q   <= '0;
            prodv_q <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh_q <= a_sh_q << KBITS;
            b_sh_q <= b_sh_q >> KBITS;
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + 1'b1;
            if (finish) begin
                prod_q  <= acc_d;
                prodv_q <= 1'b1;
            end
        end
    end

    assign bus.PROD  = prod_q;
    assign bus.PRODV = prodv_q;
    assign bus.BUSY  = (state_q == RUN);

endmodule

// File: tb/tb_mult_iter_param.sv
// Purpose: directed self-checking bench for mult_iter_param (KBITS=2 main, KBITS=1/4 side instances).
// Latency: expectations follow fixed N_ITER latency, or digit-count latency with MULT_EARLY_EXIT_EN.
// Backpressure: checks that starts during BUSY are dropped and abort wins over start.
module tb_mult_iter_param;

    logic CLK;
    logic RST_N;
    int   ncmp  = 0;
    int   nfail = 0;

    mult_iter_param_if #(.WIDTH(32)) bus  ();
    mult_iter_param_if #(.WIDTH(32)) bus1 ();
    mult_iter_param_if #(.WIDTH(32)) bus4 ();

    mult_iter_param #(.WIDTH(32), .KBITS(2)) u_dut  (.CLK(CLK), .RST_N(RST_N), .bus(bus));
    mult_iter_param #(.WIDTH(32), .KBITS(1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
    mult_iter_param #(.WIDTH(32), .KBITS(4)) u_dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Start one multiply on the KBITS=2 instance and check product, valid and latency.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp_p, input int exp_lat);
        int lat;
        @(negedge CLK);
        bus.MST = 1'b1; bus.SRCA = a; bus.SRCB = b; bus.MSGNA = sa; bus.MSGNB = sb;
        @(negedge CLK);
        bus.MST = 1'b0;
        chk({tag, "_busy"},  64'(bus.BUSY),  64'd1);
        chk({tag, "_vdrop"}, 64'(bus.PRODV), 64'd0);
        lat = 0;
        while (bus.PRODV !== 1'b1 && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, "_prodv"}, 64'(bus.PRODV), 64'd1);
        chk({tag, "_prod"},  bus.PROD,       exp_p);
        chk({tag, "_lat"},   64'(lat),       64'(exp_lat));
        chk({tag, "_idle"},  64'(bus.BUSY),  64'd0);
    endtask

    initial begin
        int l1;
        int l4;
        {bus.MST, bus.MABORT, bus.MSGNA, bus.MSGNB}     = '0;
        {bus1.MST, bus1.MABORT, bus1.MSGNA, bus1.MSGNB} = '0;
        {bus4.MST, bus4.MABORT, bus4.MSGNA, bus4.MSGNB} = '0;
        bus.SRCA = '0;  bus.SRCB = '0;
        bus1.SRCA = '0; bus1.SRCB = '0;
        bus4.SRCA = '0; bus4.SRCB = '0;

        // Reset values.
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_prod",  bus.PROD,         64'd0);
        chk("rst_prodv", 64'(bus.PRODV),   64'd0);
        chk("rst_busy",  64'(bus.BUSY),    64'd0);
        RST_N = 1'b1;

        // Four sign combinations on the KBITS=2 instance.
        do_mul("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 16);
        // Result held while idle in DONE.
        repeat (3) @(negedge CLK);
        chk("hold_prodv", 64'(bus.PRODV), 64'd1);
        chk("hold_prod",  bus.PROD,       64'hFFFF_FFFE_0000_0001);
        do_mul("ss_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 16);
        do_mul("ss_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 16);
        do_mul("su_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, 16);

        // Same signed-by-unsigned product on the radix-2 and radix-16 instances.
        @(negedge CLK);
        bus1.MST = 1'b1; bus1.SRCA = 32'hFFFF_FFFF; bus1.SRCB = 32'hFFFF_FFFF; bus1.MSGNA = 1'b1;
        bus4.MST = 1'b1; bus4.SRCA = 32'hFFFF_FFFF; bus4.SRCB = 32'hFFFF_FFFF; bus4.MSGNA = 1'b1;
        @(negedge CLK);
        bus1.MST = 1'b0; bus4.MST = 1'b0;
        l1 = 0; l4 = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (bus1.PRODV === 1'b1 && l1 == 0) l1 = c;
            if (bus4.PRODV === 1'b1 && l4 == 0) l4 = c;
        end
        chk("k1_prod", bus1.PROD, 64'hFFFF_FFFF_0000_0001);
        chk("k1_lat",  64'(l1),   64'd32);
        chk("k4_prod", bus4.PROD, 64'hFFFF_FFFF_0000_0001);
        chk("k4_lat",  64'(l4),   64'd8);

        // Abort mid-run, with an ignored start while busy.
        @(negedge CLK);
        bus.MST = 1'b1; bus.SRCA = 32'd1234; bus.SRCB = 32'd5678; bus.MSGNA = 1'b0; bus.MSGNB = 1'b0;
        @(negedge CLK);
        bus.MST = 1'b0;
        repeat (2) @(negedge CLK);
        bus.MST = 1'b1; bus.SRCA = 32'd9; bus.SRCB = 32'd9;
        @(negedge CLK);
        bus.MST = 1'b0;
        chk("busy_ign", 64'(bus.BUSY), 64'd1);
        repeat (2) @(negedge CLK);
        bus.MABORT = 1'b1;
        @(negedge CLK);
        bus.MABORT = 1'b0;
        chk("abort_busy",  64'(bus.BUSY),  64'd0);
        chk("abort_prodv", 64'(bus.PRODV), 64'd0);
        chk("abort_prod",  bus.PROD,       64'hFFFF_FFFF_0000_0001);
        repeat (20) @(negedge CLK);
        chk("noqueue_busy",  64'(bus.BUSY),  64'd0);
        chk("noqueue_prodv", 64'(bus.PRODV), 64'd0);

        // Abort together with start: start must be dropped.
        bus.MST = 1'b1; bus.MABORT = 1'b1;
        @(negedge CLK);
        bus.MST = 1'b0; bus.MABORT = 1'b0;
        chk("abort_pri_busy", 64'(bus.BUSY), 64'd0);

        do_mul("m7x6", 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, EE ? 2 : 16);

        // Abort in DONE clears valid, keeps product.
        bus.MABORT = 1'b1;
        @(negedge CLK);
        bus.MABORT = 1'b0;
        chk("abort_done_prodv", 64'(bus.PRODV), 64'd0);
        chk("abort_done_prod",  bus.PROD,       64'd42);

        // Asynchronous reset mid-run.
        @(negedge CLK);
        bus.MST = 1'b1; bus.SRCA = 32'd100; bus.SRCB = 32'd200;
        @(negedge CLK);
        bus.MST = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("arst_prod",  bus.PROD,       64'd0);
        chk("arst_prodv", 64'(bus.PRODV), 64'd0);
        chk("arst_busy",  64'(bus.BUSY),  64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_mul("post_rst", 32'd100, 32'd200, 1'b0, 1'b0, 64'd20000, EE ? 4 : 16);

        // Short multiplier and signed negative multiplier.
        do_mul("m7x3",  32'd7, 32'd3,          1'b0, 1'b0, 64'd21,                  EE ? 1 : 16);
        do_mul("m7xn3", 32'd7, 32'hFFFF_FFFD,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
